glb_access_arbiter: RTL

//  Single-port GLB access arbiter between the per-FIFO L3 controllers and the GLB SRAM port.

---
 rtl/glb_access_arbiter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/glb_access_arbiter.sv
// glb_access_arbiter: single-port GLB access arbiter.
// Arbitrates ifmap/ipsum read requesters and opsum write requesters onto one
// GLB SRAM port. At most one grant per cycle, two-level round robin (class,
// then index). The GLB command is registered. Read tags travel down an
// RD_LAT+1 deep pipeline so the return pulse lines up with glb_rdata.
// Optional feature macro: GLB_ARB_PERF_EN adds live grant/stall counters;
// without it the perf ports are tied to zero.
module glb_access_arbiter #(
  parameter int IC_MAX = 32,
  parameter int OC_MAX = 32,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IC_MAX-1:0]    ifmap_rd_req,
  input  logic [IC_MAX*32-1:0] ifmap_rd_addr,
  output logic [IC_MAX-1:0]    ifmap_rd_gnt,
  output logic [IC_MAX-1:0]    ifmap_rd_valid,
  input  logic [OC_MAX-1:0]    ipsum_rd_req,
  input  logic [OC_MAX*32-1:0] ipsum_rd_addr,
  output logic [OC_MAX-1:0]    ipsum_rd_gnt,
  output logic [OC_MAX-1:0]    ipsum_rd_valid,
  input  logic [OC_MAX-1:0]    opsum_wr_req,
  input  logic [OC_MAX*32-1:0] opsum_wr_addr,
  input  logic [OC_MAX*4-1:0]  opsum_wr_web,
  output logic [OC_MAX-1:0]    opsum_wr_gnt,
  output logic                 glb_en,
  output logic [3:0]           glb_web,
  output logic [31:0]          glb_addr,
  input  logic [31:0]          glb_rdata,
  output logic [31:0]          rd_data,
  output logic [95:0]          perf_gnt_cnt,
  output logic [31:0]          perf_stall_cnt,
  output logic [1:0]           o_dbg_class_ptr
);

  // Handshake: a requester holds req/addr/web stable until it sees gnt (a
  // one-cycle pulse, combinational from req in the same cycle); it may drop or
  // re-raise req the cycle after. A req dropped before gnt is simply forgotten.
  // rd_valid is a one-cycle pulse with no back-pressure; rd_data is valid only
  // in that cycle.

  localparam int MAXN = (IC_MAX > OC_MAX) ? IC_MAX : OC_MAX;
  localparam int IW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  typedef enum logic [1:0] {
    CL_OPSUM = 2'd0,
    CL_IPSUM = 2'd1,
    CL_IFMAP = 2'd2
  } cls_e;

  // Rotation order OPSUM -> IPSUM -> IFMAP -> OPSUM.
  function automatic cls_e cls_next(input cls_e c);
    case (c)
      CL_OPSUM: cls_next = CL_IPSUM;
      CL_IPSUM: cls_next = CL_IFMAP;
      default:  cls_next = CL_OPSUM;
    endcase
  endfunction

  // First set bit at or after ptr, wrapping within n. Returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [MAXN-1:0] req, input int n,
                                          input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!res[IW] && req[j]) res = {1'b1, IW'(j)};
      end
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i, input int n);
    if (int'(i) == n - 1) return '0;
    return i + 1'b1;
  endfunction

  // r_cls_ptr is the class examined first; r_ptr_* are the in-class start indices.
  cls_e          r_cls_ptr;
  logic [IW-1:0] r_ptr_op, r_ptr_ip, r_ptr_if;

  logic [IW:0]   w_pick_op, w_pick_ip, w_pick_if;
  logic [2:0]    w_has;
  cls_e          w_c0, w_c1, w_c2, w_gnt_cls;
  logic          w_gnt_vld;
  logic [IW-1:0] w_gnt_idx;
  logic [31:0]   w_sel_addr;
  logic [3:0]    w_sel_web;
  logic          w_is_read;

  assign w_pick_op = rr_pick(MAXN'(opsum_wr_req), OC_MAX, r_ptr_op);
  assign w_pick_ip = rr_pick(MAXN'(ipsum_rd_req), OC_MAX, r_ptr_ip);
  assign w_pick_if = rr_pick(MAXN'(ifmap_rd_req), IC_MAX, r_ptr_if);
  assign w_has     = {w_pick_if[IW], w_pick_ip[IW], w_pick_op[IW]};

  // Class-level round robin, then select the winning in-class index and its command.
  always_comb begin
    w_c0      = r_cls_ptr;
    w_c1      = cls_next(w_c0);
    w_c2      = cls_next(w_c1);
    w_gnt_vld = 1'b1;
    w_gnt_cls = w_c0;
    if (w_has[w_c0])      w_gnt_cls = w_c0;
    else if (w_has[w_c1]) w_gnt_cls = w_c1;
    else if (w_has[w_c2]) w_gnt_cls = w_c2;
    else                  w_gnt_vld = 1'b0;
    case (w_gnt_cls)
      CL_OPSUM: w_gnt_idx = w_pick_op[IW-1:0];
      CL_IPSUM: w_gnt_idx = w_pick_ip[IW-1:0];
      default:  w_gnt_idx = w_pick_if[IW-1:0];
    endcase
    w_sel_web = 4'hF;
    case (w_gnt_cls)
      CL_OPSUM: begin
        w_sel_addr = opsum_wr_addr[w_gnt_idx*32 +: 32];
        w_sel_web  = opsum_wr_web[w_gnt_idx*4 +: 4];
      end
      CL_IPSUM: w_sel_addr = ipsum_rd_addr[w_gnt_idx*32 +: 32];
      default:  w_sel_addr = ifmap_rd_addr[w_gnt_idx*32 +: 32];
    endcase
    w_is_read = w_gnt_vld && (w_gnt_cls != CL_OPSUM);
  end

  // One-hot grant pulse to the winner; suppressed while reset is asserted.
  always_comb begin
    ifmap_rd_gnt = '0;
    ipsum_rd_gnt = '0;
    opsum_wr_gnt = '0;
    if (w_gnt_vld && !rst) begin
      case (w_gnt_cls)
        CL_OPSUM: opsum_wr_gnt[w_gnt_idx] = 1'b1;
        CL_IPSUM: ipsum_rd_gnt[w_gnt_idx] = 1'b1;
        default:  ifmap_rd_gnt[w_gnt_idx] = 1'b1;
      endcase
    end
  end

  // Arbitration pointers advance past the winner, and only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls_ptr <= CL_OPSUM;
      r_ptr_op  <= '0;
      r_ptr_ip  <= '0;
      r_ptr_if  <= '0;
    end else if (w_gnt_vld) begin
      r_cls_ptr <= cls_next(w_gnt_cls);
      case (w_gnt_cls)
        CL_OPSUM: r_ptr_op <= inc_wrap(w_gnt_idx, OC_MAX);
        CL_IPSUM: r_ptr_ip <= inc_wrap(w_gnt_idx, OC_MAX);
        default:  r_ptr_if <= inc_wrap(w_gnt_idx, IC_MAX);
      endcase
    end
  end

  assign o_dbg_class_ptr = r_cls_ptr;

  // Registered GLB command; the address holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      glb_en   <= 1'b0;
      glb_web  <= 4'hF;
      glb_addr <= '0;
    end else begin
      glb_en  <= w_gnt_vld;
      glb_web <= w_gnt_vld ? w_sel_web : 4'hF;
      if (w_gnt_vld) glb_addr <= w_sel_addr;
    end
  end

  // Read tag pipeline: stage k holds the tag of a read granted k+1 cycles ago.
  logic [RD_LAT:0] r_tag_vld;
  cls_e            r_tag_cls [RD_LAT+1];
  logic [IW-1:0]   r_tag_idx [RD_LAT+1];

  // Shift tags; reset flushes any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        r_tag_cls[k] <= CL_OPSUM;
        r_tag_idx[k] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_is_read;
      r_tag_cls[0] <= w_gnt_cls;
      r_tag_idx[0] <= w_gnt_idx;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_cls[k] <= r_tag_cls[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  // Decode the oldest tag into the return pulse and forward read data with it.
  always_comb begin
    ifmap_rd_valid = '0;
    ipsum_rd_valid = '0;
    rd_data        = '0;
    if (r_tag_vld[RD_LAT] && !rst) begin
      rd_data = glb_rdata;
      if (r_tag_cls[RD_LAT] == CL_IPSUM) ipsum_rd_valid[r_tag_idx[RD_LAT]] = 1'b1;
      else                               ifmap_rd_valid[r_tag_idx[RD_LAT]] = 1'b1;
    end
  end

`ifdef GLB_ARB_PERF_EN
  logic [31:0] r_gnt_cnt [3];
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ($countones({ifmap_rd_req, ipsum_rd_req, opsum_wr_req}) >= 2);

  // Saturating per-class grant and contention counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) r_gnt_cnt[c] <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_gnt_vld && (r_gnt_cnt[w_gnt_cls] != 32'hFFFF_FFFF))
        r_gnt_cnt[w_gnt_cls] <= r_gnt_cnt[w_gnt_cls] + 32'd1;
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_gnt_cnt   = {r_gnt_cnt[2], r_gnt_cnt[1], r_gnt_cnt[0]};
  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_gnt_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
